// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: sweeps a 3-input gate through all rows,
// majority-votes its output per row and checks the truth table.
module truth_table_sweeper #(
  parameter int         SETTLE_CYCLES = 16,
  parameter int         SAMPLES       = 5,
  parameter logic [7:0] EXPECTED      = 8'hC5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       gate_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] signature,
  output logic       match
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int NW = $clog2(SAMPLES + 1);

  localparam logic [SW-1:0] SLAST =
    SW'(SETTLE_CYCLES - 1);
  localparam logic [NW-1:0] NLAST =
    NW'(SAMPLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_n;
  logic [2:0]      r_row;
  logic [2:0]      w_row_n;
  logic [SW-1:0]   r_scnt;
  logic [SW-1:0]   w_scnt_n;
  logic [NW-1:0]   r_ncnt;
  logic [NW-1:0]   w_ncnt_n;
  logic [NW-1:0]   r_ones;
  logic [NW-1:0]   w_ones_n;
  logic [NW-1:0]   w_ones_tot;
  logic            w_bit;
  logic            r_busy;
  logic            w_busy_n;
  logic            r_done;
  logic            w_done_n;
  logic [7:0]      r_sig;
  logic [7:0]      w_sig_n;
  logic            r_match;
  logic            w_match_n;

  // Ones seen in this row including the current sample.
  assign w_ones_tot = r_ones + NW'(gate_out);
  assign w_bit      = (int'(w_ones_tot) * 2) > SAMPLES;

  // Register all state and outputs; synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_row   <= 3'd0;
      r_scnt  <= '0;
      r_ncnt  <= '0;
      r_ones  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sig   <= 8'h00;
      r_match <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_row   <= w_row_n;
      r_scnt  <= w_scnt_n;
      r_ncnt  <= w_ncnt_n;
      r_ones  <= w_ones_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
      r_sig   <= w_sig_n;
      r_match <= w_match_n;
    end
  end

  // Next-state and next-output logic; abort overrides all.
  always_comb begin
    w_state_n = r_state;
    w_row_n   = r_row;
    w_scnt_n  = r_scnt;
    w_ncnt_n  = r_ncnt;
    w_ones_n  = r_ones;
    w_busy_n  = r_busy;
    w_done_n  = 1'b0;
    w_sig_n   = r_sig;
    w_match_n = r_match;

    unique case (r_state)
      ST_IDLE: begin
        w_row_n = 3'd0;
        if (start && !abort) begin
          w_state_n = ST_SETTLE;
          w_scnt_n  = '0;
          w_ncnt_n  = '0;
          w_ones_n  = '0;
          w_busy_n  = 1'b1;
          w_sig_n   = 8'h00;
          w_match_n = 1'b0;
        end
      end

      ST_SETTLE: begin
        if (r_scnt == SLAST) begin
          w_state_n = ST_SAMPLE;
          w_scnt_n  = '0;
        end else begin
          w_scnt_n = r_scnt + 1'b1;
        end
      end

      ST_SAMPLE: begin
        if (r_ncnt == NLAST) begin
          w_sig_n[3'd7 - r_row] = w_bit;
          w_ncnt_n = '0;
          w_ones_n = '0;
          if (r_row == 3'd7) begin
            w_state_n = ST_DONE;
            w_row_n   = 3'd0;
            w_busy_n  = 1'b0;
            w_done_n  = 1'b1;
            w_match_n = (w_sig_n == EXPECTED);
          end else begin
            w_state_n = ST_SETTLE;
            w_row_n   = r_row + 3'd1;
          end
        end else begin
          w_ncnt_n = r_ncnt + 1'b1;
          w_ones_n = w_ones_tot;
        end
      end

      ST_DONE: begin
        w_state_n = ST_IDLE;
        w_row_n   = 3'd0;
      end
    endcase

    if (abort && r_state != ST_IDLE) begin
      w_state_n = ST_IDLE;
      w_row_n   = 3'd0;
      w_scnt_n  = '0;
      w_ncnt_n  = '0;
      w_ones_n  = '0;
      w_busy_n  = 1'b0;
      w_done_n  = 1'b0;
      w_sig_n   = 8'h00;
      w_match_n = 1'b0;
    end
  end

  assign {in1, in2, in3} = r_row;
  assign busy            = r_busy;
  assign done            = r_done;
  assign signature       = r_sig;
  assign match           = r_match;

endmodule
